// File: rtl/udp_tx_framer_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : udp_tx_pkg
// Brief  : Shared types and helpers for the UDP transmit framer.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    HDR    = 3'd2,
    PREF   = 3'd3,
    STREAM = 3'd4
  } state_t;

  localparam int UDP_HDR_BYTES = 8;

  function automatic int ceil_div(input int len, input int bpw);
    return (len + bpw - 1) / bpw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_framer_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : udp_tx_framer_if
// Brief  : Command, payload-write, header and byte-stream bundle of the framer.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
interface udp_tx_framer_if #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_dest_ip;
  logic [31:0]      cmd_ports;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [IN_W-1:0]  wr_data;
  logic             s_udp_hdr_valid;
  logic             s_udp_hdr_ready;
  logic [31:0]      dest_ip;
  logic [15:0]      src_port;
  logic [15:0]      dest_port;
  logic [15:0]      udp_length;
  logic [7:0]       tx_data;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             tuser;
  logic             busy;
  logic             done;
  logic             len_err;

  // Framer side
  modport master (
    input  cmd_valid, cmd_dest_ip, cmd_ports, cmd_len, wr_valid, wr_data,
           s_udp_hdr_ready, tready,
    output cmd_ready, wr_ready, s_udp_hdr_valid, dest_ip, src_port, dest_port,
           udp_length, tx_data, tvalid, tlast, tuser, busy, done, len_err
  );

  // Register-file / stack side
  modport slave (
    output cmd_valid, cmd_dest_ip, cmd_ports, cmd_len, wr_valid, wr_data,
           s_udp_hdr_ready, tready,
    input  cmd_ready, wr_ready, s_udp_hdr_valid, dest_ip, src_port, dest_port,
           udp_length, tx_data, tvalid, tlast, tuser, busy, done, len_err
  );
endinterface
`default_nettype wire

// File: rtl/udp_tx_framer_buf.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : udp_tx_buf
// Brief  : Simple dual-port payload RAM, synchronous write, registered read.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
module udp_tx_buf #(
  parameter int IN_W  = 32,
  parameter int DEPTH = 375,
  parameter int AW    = 9
) (
  input  wire logic            clk,
  input  wire logic            wr_en,
  input  wire logic [AW-1:0]   wr_addr,
  input  wire logic [IN_W-1:0] wr_data,
  input  wire logic            rd_en,
  input  wire logic [AW-1:0]   rd_addr,
  output logic      [IN_W-1:0] rd_data
);
  logic [IN_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end
endmodule
`default_nettype wire

// File: rtl/udp_tx_framer.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : udp_tx_framer
// Brief  : Buffers one UDP payload, presents its header, then streams bytes.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int MAX_BYTES = 1500,
  parameter int LEN_W     = 16
) (
  input wire logic        clk,
  input wire logic        rst,
  udp_tx_framer_if.master bus
);
  localparam int BPW   = IN_W / 8;
  localparam int DEPTH = ceil_div(MAX_BYTES, BPW);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0]    c_last_bidx = BW'(BPW - 1);
  localparam logic [LEN_W-1:0] c_max_len   = LEN_W'(MAX_BYTES);

  state_t           r_state;
  logic [LEN_W-1:0] r_len, r_words, r_bcnt, r_raddr;
  logic [AW-1:0]    r_wcnt;
  logic [BW-1:0]    r_bidx;
  logic [IN_W-1:0]  r_shift;
  logic [31:0]      r_dest_ip;
  logic [15:0]      r_src_port, r_dest_port, r_udp_length;
  logic             r_cmd_ready, r_wr_ready, r_hdr_valid, r_tvalid, r_tlast;
  logic             r_busy, r_done, r_len_err;

  logic             w_we, w_hs, w_rd_req, w_rd_en;
  logic [IN_W-1:0]  w_rd_data;

  always_comb begin
    w_we     = (r_state == FILL) && r_wr_ready && bus.wr_valid;
    w_hs     = r_tvalid && bus.tready;
    // The next word is fetched as soon as the current one enters the shifter,
    // so it is always waiting in the RAM output register at a word boundary.
    w_rd_req = ((r_state == HDR) && bus.s_udp_hdr_ready) || (r_state == PREF) ||
               ((r_state == STREAM) && w_hs && (r_bidx == c_last_bidx) && !r_tlast);
    w_rd_en  = w_rd_req && (r_raddr < r_words);
  end

  udp_tx_buf #(.IN_W(IN_W), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (w_we),
    .wr_addr (r_wcnt),
    .wr_data (bus.wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_raddr[AW-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_words      <= '0;
      r_bcnt       <= '0;
      r_raddr      <= '0;
      r_wcnt       <= '0;
      r_bidx       <= '0;
      r_shift      <= '0;
      r_dest_ip    <= '0;
      r_src_port   <= '0;
      r_dest_port  <= '0;
      r_udp_length <= '0;
      r_cmd_ready  <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      if (w_rd_en) r_raddr <= r_raddr + LEN_W'(1);
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            if ((bus.cmd_len == '0) || (bus.cmd_len > c_max_len)) begin
              r_len_err <= 1'b1;
            end else begin
              r_dest_ip    <= bus.cmd_dest_ip;
              r_src_port   <= bus.cmd_ports[31:16];
              r_dest_port  <= bus.cmd_ports[15:0];
              r_len        <= bus.cmd_len;
              r_words      <= LEN_W'(ceil_div(int'(bus.cmd_len), BPW));
              r_udp_length <= 16'(bus.cmd_len) + 16'(UDP_HDR_BYTES);
              r_wcnt       <= '0;
              r_raddr      <= '0;
              r_cmd_ready  <= 1'b0;
              r_wr_ready   <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= FILL;
            end
          end
        end
        FILL: begin
          if (w_we) begin
            r_wcnt <= r_wcnt + AW'(1);
            if (LEN_W'(r_wcnt) == r_words - LEN_W'(1)) begin
              r_wr_ready  <= 1'b0;
              r_hdr_valid <= 1'b1;
              r_state     <= HDR;
            end
          end
        end
        HDR: begin
          if (bus.s_udp_hdr_ready) begin
            r_hdr_valid <= 1'b0;
            r_bcnt      <= '0;
            r_state     <= PREF;
          end
        end
        PREF: begin
          r_shift  <= w_rd_data;
          r_bidx   <= '0;
          r_tvalid <= 1'b1;
          r_tlast  <= (r_len == LEN_W'(1));
          r_state  <= STREAM;
        end
        STREAM: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_tvalid    <= 1'b0;
              r_tlast     <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_bcnt  <= r_bcnt + LEN_W'(1);
              r_tlast <= (r_bcnt + LEN_W'(2) == r_len);
              if (r_bidx == c_last_bidx) begin
                r_shift <= w_rd_data;
                r_bidx  <= '0;
              end else begin
                r_shift <= r_shift << 8;
                r_bidx  <= r_bidx + BW'(1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.wr_ready        = r_wr_ready;
  assign bus.s_udp_hdr_valid = r_hdr_valid;
  assign bus.dest_ip         = r_dest_ip;
  assign bus.src_port        = r_src_port;
  assign bus.dest_port       = r_dest_port;
  assign bus.udp_length      = r_udp_length;
  assign bus.tx_data         = r_shift[IN_W-1 -: 8];
  assign bus.tvalid          = r_tvalid;
  assign bus.tlast           = r_tlast;
  assign bus.tuser           = 1'b0;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.len_err         = r_len_err;
endmodule
`default_nettype wire
